// File: rtl/hilo_md_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states, data width.
package hilo_md_pkg;

    localparam int MD_W = 32;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // Ops that occupy the unit for several cycles and stall the pipeline.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/hilo_md_unit_mul_pipe.sv
// MUL_LAT-stage 33x33 signed multiplier; unsigned operands arrive zero-extended to 33 bits.
module md_mul_pipe
    import hilo_md_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [MD_W:0]       a,
    input  logic [MD_W:0]       b,
    output logic [2*MD_W-1:0]   prod,
    output logic                out_valid
);

    logic signed [2*MD_W+1:0] full;
    logic [1:0]               full_unused;

    // Only the low 64 bits of the 66-bit product are architecturally visible.
    assign full        = $signed(a) * $signed(b);
    assign full_unused = full[2*MD_W+1:2*MD_W];

    generate
        if (MUL_LAT == 1) begin : g_comb
            assign prod      = full[2*MD_W-1:0];
            assign out_valid = in_valid;
        end else begin : g_pipe
            logic [2*MD_W-1:0] stage_q [MUL_LAT-1];
            logic [MUL_LAT-2:0] vld_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < MUL_LAT-1; i++) stage_q[i] <= '0;
                    vld_q <= '0;
                end else begin
                    stage_q[0] <= full[2*MD_W-1:0];
                    vld_q[0]   <= in_valid;
                    for (int i = 1; i < MUL_LAT-1; i++) begin
                        stage_q[i] <= stage_q[i-1];
                        vld_q[i]   <= vld_q[i-1];
                    end
                end
            end

            assign prod      = stage_q[MUL_LAT-2];
            assign out_valid = vld_q[MUL_LAT-2];
        end
    endgenerate

endmodule

// File: rtl/hilo_md_unit.sv
// EXE-stage multiply/divide sequencer and HI/LO owner; drives the external iterative Divider.
//   state | meaning
//   IDLE  | no long op; MTHI/MTLO write directly; MULT/DIV issue from here
//   MUL   | internal multiplier running, counter tracks MUL_LAT cycles
//   DIV   | Divider started, waiting for div_busy to fall
//   DONE  | result committed, waiting for the instruction to leave EXE
module hilo_md_unit
    import hilo_md_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    input  logic [2:0]          op,
    input  logic [MD_W-1:0]     rs_val,
    input  logic [MD_W-1:0]     rt_val,
    input  logic                ex_hold,
    input  logic                flush,
    output logic                div_start,
    output logic                div_clr,
    output logic                div_sign,
    output logic [MD_W-1:0]     div_a,
    output logic [MD_W-1:0]     div_b,
    input  logic [2*MD_W-1:0]   div_result,
    input  logic                div_busy,
    output logic [MD_W-1:0]     hi,
    output logic [MD_W-1:0]     lo,
    output logic                md_stall
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    md_state_e          state;
    logic [CW-1:0]      mul_cnt;
    logic [MD_W:0]      mul_a;
    logic [MD_W:0]      mul_b;
    logic [2*MD_W-1:0]  mul_prod;
    logic               mul_valid;
    logic               mul_done;
    logic               mul_signed;

    assign div_clr    = flush;
    assign mul_signed = (op == MD_MULT);
    assign mul_done   = mul_valid && (mul_cnt == CW'(MUL_LAT-1));

    assign md_stall = ((state == ST_IDLE) && op_valid && is_long_op(op) && !flush)
                   || (state == ST_MUL) || (state == ST_DIV);

    md_mul_pipe #(
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .in_valid  ((state == ST_MUL) && (mul_cnt == '0)),
        .a         (mul_a),
        .b         (mul_b),
        .prod      (mul_prod),
        .out_valid (mul_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            hi        <= '0;
            lo        <= '0;
            div_start <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            div_sign  <= 1'b0;
            mul_cnt   <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else if (flush) begin
            // Flush wins over any same-cycle completion; committed results stay.
            state     <= ST_IDLE;
            div_start <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op)
                            MD_MTHI: if (!ex_hold) hi <= rs_val;
                            MD_MTLO: if (!ex_hold) lo <= rs_val;
                            MD_DIV, MD_DIVU: begin
                                div_a     <= rs_val;
                                div_b     <= rt_val;
                                div_sign  <= (op == MD_DIV);
                                div_start <= 1'b1;
                                state     <= ST_DIV;
                            end
                            MD_MULT, MD_MULTU: begin
                                mul_a   <= {mul_signed & rs_val[MD_W-1], rs_val};
                                mul_b   <= {mul_signed & rt_val[MD_W-1], rt_val};
                                mul_cnt <= '0;
                                state   <= ST_MUL;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    mul_cnt <= mul_cnt + CW'(1);
                    if (mul_done) begin
                        hi    <= mul_prod[2*MD_W-1:MD_W];
                        lo    <= mul_prod[MD_W-1:0];
                        state <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    if (!div_busy) begin
                        hi        <= div_result[2*MD_W-1:MD_W];
                        lo        <= div_result[MD_W-1:0];
                        div_start <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!ex_hold) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_md_unit.sv
// Scoreboard bench for hilo_md_unit with a behavioural iterative Divider model.
module tb_hilo_md_unit;
    import hilo_md_pkg::*;

    localparam int K_NORM = 33;
    localparam int K_ZERO = 36;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        ex_hold, flush;
    logic        div_start, div_clr, div_sign;
    logic [31:0] div_a, div_b;
    logic [63:0] div_result;
    logic        div_busy;
    logic [31:0] hi, lo;
    logic        md_stall;

    typedef struct { logic [31:0] hi; logic [31:0] lo; } hl_t;
    hl_t exp_q[$];
    hl_t e;

    int checks = 0;
    int failures = 0;
    int dcnt;
    int ds_rises = 0;
    logic ds_prev = 1'b0;

    hilo_md_unit #(.MUL_LAT(2)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .ex_hold(ex_hold), .flush(flush),
        .div_start(div_start), .div_clr(div_clr), .div_sign(div_sign),
        .div_a(div_a), .div_b(div_b), .div_result(div_result), .div_busy(div_busy),
        .hi(hi), .lo(lo), .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q, r;
        if (b == 0) return 64'd0;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) dcnt <= 0;
        else if (div_clr || !div_start) dcnt <= 0;
        else if (dcnt < 1000) dcnt <= dcnt + 1;
    end
    assign div_busy   = div_start && (dcnt < ((div_b == 0) ? K_ZERO : K_NORM));
    assign div_result = model_div(div_a, div_b, div_sign);

    always @(posedge clk) begin
        if (div_start && !ds_prev) ds_rises++;
        ds_prev = div_start;
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // Holds the op in EXE and counts stalled cycles until md_stall drops (bounded).
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic hold, output int stalls);
        op_valid = 1'b1; op = o; rs_val = a; rt_val = b; ex_hold = hold;
        #1;
        stalls = 0;
        while (md_stall === 1'b1 && stalls < 300) begin
            stalls++;
            @(posedge clk); #2;
        end
    endtask

    task automatic release_op();
        op_valid = 1'b0; op = MD_NONE; ex_hold = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL reset_div_start got=%b exp=0", div_start); end
        checks++; if (div_a !== 32'd0 || div_b !== 32'd0) begin failures++; $display("FAIL reset_div_ops got=%h/%h exp=0/0", div_a, div_b); end
        checks++; if (div_sign !== 1'b0) begin failures++; $display("FAIL reset_div_sign got=%b exp=0", div_sign); end
        checks++; if (md_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", md_stall); end
        checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, ST_IDLE); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_div_signed();
        int st;
        exp_q.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, st);
        checks++; if (st !== 35) begin failures++; $display("FAIL div_stall_cycles got=%0d exp=35", st); end
        e = exp_q.pop_front();
        checks++; if (hi !== e.hi || lo !== e.lo) begin failures++; $display("FAIL div_result got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo); end
        checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL div_start_drop got=%b exp=0", div_start); end
        checks++; if (dut.state !== ST_DONE) begin failures++; $display("FAIL div_done_state got=%0d exp=%0d", dut.state, ST_DONE); end
        release_op();
    endtask

    task automatic test_divu_zero();
        int st;
        exp_q.push_back('{32'd0, 32'd0});
        issue(MD_DIVU, 32'd100, 32'd0, 1'b0, st);
        checks++; if (st !== 38) begin failures++; $display("FAIL divz_stall_cycles got=%0d exp=38", st); end
        e = exp_q.pop_front();
        checks++; if (hi !== e.hi || lo !== e.lo) begin failures++; $display("FAIL divz_result got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo); end
        release_op();
        checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL divz_idle got=%0d exp=%0d", dut.state, ST_IDLE); end
    endtask

    task automatic test_mult();
        int st;
        exp_q.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFE});
        issue(MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, st);
        checks++; if (st !== 3) begin failures++; $display("FAIL mult_stall_cycles got=%0d exp=3", st); end
        e = exp_q.pop_front();
        checks++; if (hi !== e.hi || lo !== e.lo) begin failures++; $display("FAIL mult_result got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo); end
        release_op();
        exp_q.push_back('{32'h0000_0001, 32'hFFFF_FFFE});
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, st);
        checks++; if (st !== 3) begin failures++; $display("FAIL multu_stall_cycles got=%0d exp=3", st); end
        e = exp_q.pop_front();
        checks++; if (hi !== e.hi || lo !== e.lo) begin failures++; $display("FAIL multu_result got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo); end
        release_op();
    endtask

    task automatic test_flush();
        int st;
        logic [31:0] hi0, lo0;
        hi0 = hi; lo0 = lo;
        op_valid = 1'b1; op = MD_DIV; rs_val = 32'd80; rt_val = 32'd3; ex_hold = 1'b0;
        repeat (10) cyc();
        flush = 1'b1;
        #1;
        checks++; if (div_clr !== 1'b1) begin failures++; $display("FAIL flush_div_clr got=%b exp=1", div_clr); end
        cyc();
        flush = 1'b0; op_valid = 1'b0; op = MD_NONE;
        #1;
        checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL flush_state got=%0d exp=%0d", dut.state, ST_IDLE); end
        checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL flush_div_start got=%b exp=0", div_start); end
        checks++; if (hi !== hi0 || lo !== lo0) begin failures++; $display("FAIL flush_hilo got=%h_%h exp=%h_%h", hi, lo, hi0, lo0); end
        cyc();
        exp_q.push_back('{32'd1, 32'd2});
        issue(MD_DIVU, 32'd9, 32'd4, 1'b0, st);
        checks++; if (st !== 35) begin failures++; $display("FAIL divu94_stall got=%0d exp=35", st); end
        e = exp_q.pop_front();
        checks++; if (hi !== e.hi || lo !== e.lo) begin failures++; $display("FAIL divu94_result got=%h_%h exp=%h_%h", hi, lo, e.hi, e.lo); end
        release_op();
        op_valid = 1'b1; op = MD_MTLO; rs_val = 32'hDEAD_BEEF; flush = 1'b1;
        cyc();
        flush = 1'b0; op_valid = 1'b0; op = MD_NONE;
        #1;
        checks++; if (lo !== 32'd2) begin failures++; $display("FAIL mt_flush_suppress got=%h exp=2", lo); end
        cyc();
    endtask

    task automatic test_mthi_hold();
        logic [31:0] hi0;
        hi0 = hi;
        op_valid = 1'b1; op = MD_MTHI; rs_val = 32'h1234_5678; ex_hold = 1'b1;
        #1;
        checks++; if (md_stall !== 1'b0) begin failures++; $display("FAIL mthi_no_stall got=%b exp=0", md_stall); end
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++; if (hi !== hi0) begin failures++; $display("FAIL mthi_held_%0d got=%h exp=%h", i, hi, hi0); end
        end
        ex_hold = 1'b0;
        cyc();
        checks++; if (hi !== 32'h1234_5678) begin failures++; $display("FAIL mthi_write got=%h exp=12345678", hi); end
        op_valid = 1'b0; op = MD_NONE;
        cyc();
    endtask

    task automatic test_div_hold();
        int st, r0;
        r0 = ds_rises;
        exp_q.push_back('{32'd6, 32'd142});
        issue(MD_DIV, 32'd1000, 32'd7, 1'b1, st);
        checks++; if (st !== 35) begin failures++; $display("FAIL divhold_stall got=%0d exp=35", st); end
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            checks++; if (dut.state !== ST_DONE) begin failures++; $display("FAIL divhold_done_%0d got=%0d exp=%0d", i, dut.state, ST_DONE); end
            checks++; if (hi !== e.hi || lo !== e.lo || div_start !== 1'b0) begin
                failures++; $display("FAIL divhold_hold_%0d got=%h_%h start=%b exp=%h_%h start=0", i, hi, lo, div_start, e.hi, e.lo);
            end
            if (i == 3) begin op_valid = 1'b0; op = MD_NONE; ex_hold = 1'b0; end
            cyc();
        end
        checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL divhold_idle got=%0d exp=%0d", dut.state, ST_IDLE); end
        checks++; if (ds_rises - r0 !== 1) begin failures++; $display("FAIL divhold_start_pulses got=%0d exp=1", ds_rises - r0); end
    endtask

    task automatic test_async_reset();
        op_valid = 1'b1; op = MD_DIV; rs_val = 32'd50; rt_val = 32'd5; ex_hold = 1'b0;
        repeat (5) cyc();
        #2 rst = 1'b1;
        #1;
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL arst_hilo got=%h_%h exp=0_0", hi, lo); end
        checks++; if (div_start !== 1'b0) begin failures++; $display("FAIL arst_div_start got=%b exp=0", div_start); end
        checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL arst_state got=%0d exp=%0d", dut.state, ST_IDLE); end
        op_valid = 1'b0; op = MD_NONE;
        #2 rst = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op = MD_NONE; rs_val = '0; rt_val = '0;
        ex_hold = 1'b0; flush = 1'b0;
        test_reset();
        test_div_signed();
        test_divu_zero();
        test_mult();
        test_flush();
        test_mthi_hold();
        test_div_hold();
        test_async_reset();
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
